// File: rtl/volume_ramp_if.sv
// Sample stream interface for the volume ramp: upstream samples in, scaled samples out.
// The master modport is the side that feeds samples in and takes results out.
interface volume_ramp_if #(
    parameter int DATA_W = 24
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/volume_ramp.sv
// Output gain stage: scales signed samples by a Q2.14 gain that ramps linearly toward its
// target (or toward 0 on mute), then rounds and saturates, over a 2-stage valid/ready pipeline.
module volume_ramp #(
    parameter int DATA_W    = 24,
    parameter int GAIN_W    = 16,
    parameter int RAMP_STEP = 64
) (
    input  logic              clk,
    input  logic              reset,
    volume_ramp_if.slave      bus,
    input  logic [GAIN_W-1:0] i_targetGain,
    input  logic              i_mute,
    output logic              o_clip,
    output logic [GAIN_W-1:0] o_curGain
);
    localparam int PROD_W = DATA_W + GAIN_W + 1;
    localparam int FRAC_W = GAIN_W - 2;
    localparam logic signed [PROD_W-1:0] ROUND_BIAS = PROD_W'(1) << (FRAC_W - 1);
    localparam logic signed [PROD_W-1:0] SAT_MAX    = (PROD_W'(1) << (DATA_W - 1)) - PROD_W'(1);
    localparam logic signed [PROD_W-1:0] SAT_MIN    = ~SAT_MAX;

    typedef enum logic [1:0] {HOLD, RAMP_UP, RAMP_DOWN} gainState_t;

    gainState_t               r_state;
    gainState_t               w_stateNext;
    logic [GAIN_W-1:0]        r_curGain;
    logic [GAIN_W-1:0]        w_gainNext;
    logic [GAIN_W-1:0]        w_target;
    logic [GAIN_W:0]          w_gainUp;
    logic [GAIN_W:0]          w_gainDown;
    logic [GAIN_W-1:0]        w_upResult;
    logic [GAIN_W-1:0]        w_downResult;
    logic                     w_accept;
    logic                     w_s1Adv;

    logic                     r_s1Valid;
    logic signed [DATA_W-1:0] r_s1Data;
    logic [GAIN_W-1:0]        r_s1Gain;

    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] w_round;
    logic [DATA_W-1:0]        w_satData;
    logic                     w_sat;

    logic                     r_outValid;
    logic [DATA_W-1:0]        r_outData;
    logic                     r_clip;

    assign w_s1Adv      = r_s1Valid & (~r_outValid | bus.out_ready);
    assign bus.in_ready = ~r_s1Valid | w_s1Adv;
    assign w_accept     = bus.in_valid & bus.in_ready;
    assign w_target     = i_mute ? '0 : i_targetGain;

    // One extra bit keeps the step from wrapping past full scale or below zero.
    assign w_gainUp     = {1'b0, r_curGain} + (GAIN_W+1)'(RAMP_STEP);
    assign w_gainDown   = {1'b0, r_curGain} - (GAIN_W+1)'(RAMP_STEP);
    assign w_upResult   = (w_gainUp >= {1'b0, w_target}) ? w_target : w_gainUp[GAIN_W-1:0];
    assign w_downResult = (w_gainDown[GAIN_W] || (w_gainDown[GAIN_W-1:0] <= w_target))
                          ? w_target : w_gainDown[GAIN_W-1:0];

    always_comb begin
        w_stateNext = r_state;
        w_gainNext  = r_curGain;
        if (w_accept) begin
            case (r_state)
                RAMP_UP: begin
                    if (w_target >= r_curGain) begin
                        w_gainNext  = w_upResult;
                        w_stateNext = (w_upResult == w_target) ? HOLD : RAMP_UP;
                    end else begin
                        w_gainNext  = w_downResult;
                        w_stateNext = (w_downResult == w_target) ? HOLD : RAMP_DOWN;
                    end
                end
                RAMP_DOWN: begin
                    if (w_target <= r_curGain) begin
                        w_gainNext  = w_downResult;
                        w_stateNext = (w_downResult == w_target) ? HOLD : RAMP_DOWN;
                    end else begin
                        w_gainNext  = w_upResult;
                        w_stateNext = (w_upResult == w_target) ? HOLD : RAMP_UP;
                    end
                end
                default: begin
                    if (w_target > r_curGain) begin
                        w_gainNext  = w_upResult;
                        w_stateNext = (w_upResult == w_target) ? HOLD : RAMP_UP;
                    end else if (w_target < r_curGain) begin
                        w_gainNext  = w_downResult;
                        w_stateNext = (w_downResult == w_target) ? HOLD : RAMP_DOWN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= HOLD;
            r_curGain <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_curGain <= w_gainNext;
        end
    end

    // Stage 1 captures the gain as it stood before this sample's ramp step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1Valid <= 1'b0;
            r_s1Data  <= '0;
            r_s1Gain  <= '0;
        end else if (w_accept) begin
            r_s1Valid <= 1'b1;
            r_s1Data  <= bus.in_data;
            r_s1Gain  <= r_curGain;
        end else if (w_s1Adv) begin
            r_s1Valid <= 1'b0;
        end
    end

    assign w_prod  = r_s1Data * $signed({1'b0, r_s1Gain});
    assign w_round = (w_prod + ROUND_BIAS) >>> FRAC_W;

    always_comb begin
        w_sat     = 1'b0;
        w_satData = w_round[DATA_W-1:0];
        if (w_round > SAT_MAX) begin
            w_sat     = 1'b1;
            w_satData = SAT_MAX[DATA_W-1:0];
        end else if (w_round < SAT_MIN) begin
            w_sat     = 1'b1;
            w_satData = SAT_MIN[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_outValid <= 1'b0;
            r_outData  <= '0;
            r_clip     <= 1'b0;
        end else begin
            r_clip <= w_s1Adv & w_sat;
            if (w_s1Adv) begin
                r_outValid <= 1'b1;
                r_outData  <= w_satData;
            end else if (bus.out_ready) begin
                r_outValid <= 1'b0;
            end
        end
    end

    assign bus.out_data  = r_outData;
    assign bus.out_valid = r_outValid;
    assign o_clip        = r_clip;
    assign o_curGain     = r_curGain;
endmodule
